// File: rtl/prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : prefetch_queue
// Description : Credit-limited instruction prefetch queue with jump redirect,
//               draining of stale in-flight responses after a redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module prefetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              sys_clk,
    input  logic              rst,
    output logic              req_valid,
    output logic [ADDR_W-1:0] req_addr,
    input  logic              req_ready,
    input  logic              resp_valid,
    input  logic [DATA_W-1:0] resp_data,
    output logic              ins_valid,
    output logic [DATA_W-1:0] ins_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] next_pc_out,
    input  logic              ins_ready,
    input  logic              do_jump,
    input  logic [ADDR_W-1:0] jump_addr
);

    localparam int                 c_PTR_W     = $clog2(DEPTH);
    localparam int                 c_CNT_W     = c_PTR_W + 1;
    localparam logic [c_CNT_W:0]   c_DEPTH_EXT = (c_CNT_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0]  c_PC_STEP   = ADDR_W'(4);
    localparam logic [0:0]         c_ST_RUN    = 1'b0;
    localparam logic [0:0]         c_ST_DRAIN  = 1'b1;

    logic [0:0]         r_state;
    logic [ADDR_W-1:0]  r_fetch_pc;
    logic [ADDR_W-1:0]  r_resp_pc;
    logic [c_CNT_W-1:0] r_outstanding;
    logic [c_CNT_W-1:0] r_discard;
    logic [c_CNT_W-1:0] r_count;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [DATA_W-1:0]  r_data_mem [DEPTH];
    logic [ADDR_W-1:0]  r_pc_mem   [DEPTH];

    logic [c_CNT_W:0]   w_credits;
    logic               w_req_fire;
    logic               w_push;
    logic               w_drop;
    logic               w_pop;
    logic [c_CNT_W-1:0] w_jump_out;

    assign w_credits  = {1'b0, r_count} + {1'b0, r_outstanding};
    assign req_valid  = !rst && (r_state == c_ST_RUN) && !do_jump && (w_credits < c_DEPTH_EXT);
    assign req_addr   = r_fetch_pc;
    assign w_req_fire = req_valid && req_ready;
    assign w_push     = resp_valid && (r_state == c_ST_RUN) && !do_jump;
    assign w_drop     = resp_valid && (r_state == c_ST_DRAIN) && !do_jump;
    assign w_pop      = (r_count != '0) && ins_ready && !do_jump;
    // A response landing in the redirect cycle retires one outstanding request.
    assign w_jump_out = r_outstanding - c_CNT_W'(resp_valid && (r_outstanding != '0));

    assign ins_valid   = (r_count != '0);
    assign ins_out     = ins_valid ? r_data_mem[r_rd_ptr] : '0;
    assign pc_out      = ins_valid ? r_pc_mem[r_rd_ptr] : '0;
    assign next_pc_out = ins_valid ? (r_pc_mem[r_rd_ptr] + c_PC_STEP) : '0;

    always_ff @(posedge sys_clk) begin
        if (w_push) begin
            r_data_mem[r_wr_ptr] <= resp_data;
            r_pc_mem[r_wr_ptr]   <= r_resp_pc;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state       <= c_ST_RUN;
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_count       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
        end else if (do_jump) begin
            r_fetch_pc    <= jump_addr;
            r_resp_pc     <= jump_addr;
            r_count       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_outstanding <= w_jump_out;
            r_discard     <= w_jump_out;
            r_state       <= (w_jump_out != '0) ? c_ST_DRAIN : c_ST_RUN;
        end else begin
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + c_PC_STEP;
            end
            if (w_push) begin
                r_wr_ptr  <= r_wr_ptr + 1'b1;
                r_resp_pc <= r_resp_pc + c_PC_STEP;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_outstanding <= r_outstanding + c_CNT_W'(w_req_fire) - c_CNT_W'(w_push || w_drop);
            if (w_drop) begin
                r_discard <= r_discard - 1'b1;
                if (r_discard == c_CNT_W'(1)) begin
                    r_state <= c_ST_RUN;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_prefetch_queue
// Description : Self-checking bench for prefetch_queue with in-order memory
//               responder and queue-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prefetch_queue;

    localparam int          ADDR_W   = 32;
    localparam int          DATA_W   = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_ready = 1'b0, resp_valid = 1'b0, ins_ready = 1'b0, do_jump = 1'b0;
    logic [31:0] resp_data = '0, jump_addr = '0;
    logic        req_valid, ins_valid;
    logic [31:0] req_addr, ins_out, pc_out, next_pc_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prefetch_queue #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .sys_clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .ins_valid(ins_valid), .ins_out(ins_out), .pc_out(pc_out),
        .next_pc_out(next_pc_out), .ins_ready(ins_ready),
        .do_jump(do_jump), .jump_addr(jump_addr)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    // ---------------- in-order instruction memory ----------------
    typedef struct { logic [31:0] addr; int due; } pend_t;
    pend_t       pend[$];
    pend_t       pend_e;
    int          cyc = 0;
    int          mem_lat = 1;
    bit          mem_lat_rand = 0, mem_hold = 0, ready_rand = 0, resp_rand = 0;
    logic        mem_hs = 1'b0;
    logic [31:0] mem_hs_addr = '0;

    always @(negedge clk) begin
        req_ready = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (!mem_hold && pend.size() > 0 && pend[0].due <= cyc && (!resp_rand || $urandom_range(0, 2) != 0)) begin
            resp_valid = 1'b1;
            resp_data  = mem_word(pend[0].addr);
        end else begin
            resp_valid = 1'b0;
            resp_data  = $urandom;
        end
        #2;
        mem_hs      = req_valid && req_ready;
        mem_hs_addr = req_addr;
    end

    always @(posedge clk) begin
        if (rst) begin
            pend.delete();
        end else begin
            if (resp_valid) void'(pend.pop_front());
            if (mem_hs) begin
                pend_e.addr = mem_hs_addr;
                pend_e.due  = cyc + (mem_lat_rand ? int'($urandom_range(1, 4)) : mem_lat);
                pend.push_back(pend_e);
            end
        end
        cyc++;
    end

    // ---------------- reference model (queue level) ----------------
    typedef struct { logic [31:0] d; logic [31:0] pc; } ent_t;
    ent_t        m_q[$];
    ent_t        m_e;
    int          m_out = 0, m_disc = 0;
    logic [31:0] m_fetch = RESET_PC, m_resp = RESET_PC;
    bit          m_hs;

    function automatic bit exp_req_valid();
        return !rst && (m_disc == 0) && !do_jump && (m_q.size() + m_out < DEPTH);
    endfunction

    always @(posedge clk) begin
        m_hs = exp_req_valid() && req_ready;
        if (rst) begin
            m_q.delete(); m_out = 0; m_disc = 0; m_fetch = RESET_PC; m_resp = RESET_PC;
        end else if (do_jump) begin
            m_q.delete();
            if (resp_valid && m_out > 0) m_out--;
            m_disc  = m_out;
            m_fetch = jump_addr;
            m_resp  = jump_addr;
        end else begin
            if (m_q.size() > 0 && ins_ready) void'(m_q.pop_front());
            if (resp_valid) begin
                if (m_disc > 0) begin
                    m_disc--; m_out--;
                end else begin
                    m_e.d = resp_data; m_e.pc = m_resp;
                    m_q.push_back(m_e);
                    m_resp += 4; m_out--;
                end
            end
            if (m_hs) begin m_fetch += 4; m_out++; end
        end
    end

    // Leaves the caller #1 into the first cycle after reset release.
    task automatic reset_dut(input int n);
        @(negedge clk); rst = 1'b1; do_jump = 1'b0; ins_ready = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic set_mem(input int lat, input bit lrand, input bit rrand, input bit prand);
        mem_lat = lat; mem_lat_rand = lrand; ready_rand = rrand; resp_rand = prand; mem_hold = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        set_mem(1, 0, 0, 0);
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", req_valid); end
        checks++; if (req_addr !== RESET_PC) begin errors++; $display("FAIL reset_req_addr: got %h expected %h", req_addr, RESET_PC); end
        checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL reset_ins_valid: got %b expected 0", ins_valid); end
        checks++; if ({ins_out, pc_out, next_pc_out} !== 96'h0) begin errors++; $display("FAIL reset_outputs: got %h %h %h expected zeros", ins_out, pc_out, next_pc_out); end
    endtask

    task automatic test_stream();
        set_mem(1, 0, 0, 0);
        reset_dut(3);
        ins_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) begin @(negedge clk); #1; end
            checks++; if (req_valid !== 1'b1 || req_addr !== 32'(4 * c)) begin errors++; $display("FAIL stream_req c=%0d: got valid=%b addr=%h expected 1 %h", c, req_valid, req_addr, 32'(4 * c)); end
            checks++; if (ins_valid !== 1'(c >= 2)) begin errors++; $display("FAIL stream_ins_valid c=%0d: got %b expected %b", c, ins_valid, c >= 2); end
            if (c >= 2) begin
                checks++; if (pc_out !== 32'(4 * (c - 2)) || next_pc_out !== 32'(4 * (c - 1)) || ins_out !== mem_word(32'(4 * (c - 2)))) begin
                    errors++; $display("FAIL stream_head c=%0d: got pc=%h next=%h ins=%h expected %h %h %h", c, pc_out, next_pc_out, ins_out, 32'(4 * (c - 2)), 32'(4 * (c - 1)), mem_word(32'(4 * (c - 2))));
                end
            end
        end
        ins_ready = 1'b0;
    endtask

    task automatic test_stall();
        int n;
        set_mem(1, 0, 0, 0);
        reset_dut(3);
        n = 0;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) begin @(negedge clk); #1; end
            if (req_valid && req_ready) n++;
        end
        checks++; if (n != 4) begin errors++; $display("FAIL stall_requests: got %0d expected 4", n); end
        checks++; if (req_valid !== 1'b0 || ins_valid !== 1'b1 || pc_out !== 32'h0) begin errors++; $display("FAIL stall_full: got req_valid=%b ins_valid=%b pc=%h expected 0 1 0", req_valid, ins_valid, pc_out); end
        @(negedge clk); ins_ready = 1'b1; #1;
        @(negedge clk); ins_ready = 1'b0; #1;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) begin @(negedge clk); #1; end
            if (req_valid && req_ready) n++;
        end
        checks++; if (n != 1) begin errors++; $display("FAIL stall_one_pop: got %0d requests expected 1", n); end
        checks++; if (pc_out !== 32'h4) begin errors++; $display("FAIL stall_head_after_pop: got %h expected 4", pc_out); end
    endtask

    task automatic test_jump_drain();
        int n, drops; bit got, bad;
        set_mem(1, 0, 0, 0);
        mem_hold = 1;
        reset_dut(3);
        n = 0;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) begin @(negedge clk); #1; end
            if (req_valid && req_ready) n++;
        end
        checks++; if (n != 3) begin errors++; $display("FAIL jd_setup: got %0d requests expected 3", n); end
        @(negedge clk); do_jump = 1'b1; jump_addr = 32'h100; #1;
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL jd_jump_cycle_req: got %b expected 0", req_valid); end
        @(negedge clk); do_jump = 1'b0; #1;
        checks++; if (ins_valid !== 1'b0 || req_valid !== 1'b0) begin errors++; $display("FAIL jd_drain_entry: got ins_valid=%b req_valid=%b expected 0 0", ins_valid, req_valid); end
        mem_hold = 0;
        drops = 0; got = 0; bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            if (ins_valid) bad = 1;
            if (req_valid) begin
                got = 1;
                checks++; if (req_addr !== 32'h100) begin errors++; $display("FAIL jd_first_req: got %h expected 00000100", req_addr); end
                break;
            end
            if (resp_valid) drops++;
        end
        checks++; if (!got || drops != 3 || bad) begin errors++; $display("FAIL jd_drain: got resumed=%0d drops=%0d ins_seen=%0d expected 1 3 0", got, drops, bad); end
        ins_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            if (ins_valid) begin got = 1; break; end
        end
        checks++; if (!got || pc_out !== 32'h100 || ins_out !== mem_word(32'h100)) begin errors++; $display("FAIL jd_first_ins: got valid=%0d pc=%h ins=%h expected 1 00000100 %h", got, pc_out, ins_out, mem_word(32'h100)); end
        ins_ready = 1'b0;
    endtask

    task automatic test_jump_resp_pop();
        int exp_disc, drops; bit got;
        set_mem(2, 0, 0, 0);
        reset_dut(3);
        repeat (4) @(negedge clk);
        do_jump = 1'b1; jump_addr = 32'h2000; ins_ready = 1'b1; #1;
        checks++; if (resp_valid !== 1'b1 || ins_valid !== 1'b1) begin errors++; $display("FAIL jrp_setup: got resp_valid=%b ins_valid=%b expected 1 1", resp_valid, ins_valid); end
        exp_disc = m_out - 1;
        @(negedge clk); do_jump = 1'b0; ins_ready = 1'b0; #1;
        checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL jrp_cleared: got ins_valid=%b expected 0", ins_valid); end
        drops = 0; got = 0;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) begin @(negedge clk); #1; end
            if (req_valid) begin got = 1; break; end
            if (resp_valid) drops++;
        end
        checks++; if (!got || drops != exp_disc || req_addr !== 32'h2000) begin errors++; $display("FAIL jrp_discard: got resumed=%0d drops=%0d addr=%h expected 1 %0d 00002000", got, drops, req_addr, exp_disc); end
        mem_lat = 1;
    endtask

    task automatic test_steady();
        set_mem(1, 0, 0, 0);
        reset_dut(3);
        for (int c = 0; c < 10; c++) begin
            if (m_q.size() == 2) break;
            @(negedge clk); #1;
        end
        ins_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            checks++; if (ins_valid !== 1'b1 || req_valid !== 1'b1 || pc_out !== 32'(4 * i) || next_pc_out !== 32'(4 * i + 4) || ins_out !== mem_word(32'(4 * i))) begin
                errors++; $display("FAIL steady i=%0d: got iv=%b rv=%b pc=%h next=%h ins=%h expected 1 1 %h %h %h", i, ins_valid, req_valid, pc_out, next_pc_out, ins_out, 32'(4 * i), 32'(4 * i + 4), mem_word(32'(4 * i)));
            end
        end
        ins_ready = 1'b0;
    endtask

    task automatic test_reset_mid_drain();
        set_mem(1, 0, 0, 0);
        mem_hold = 1;
        reset_dut(3);
        repeat (3) @(negedge clk);
        do_jump = 1'b1; jump_addr = 32'h300; #1;
        @(negedge clk); do_jump = 1'b0; #1;
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL rmd_in_drain: got req_valid=%b expected 0", req_valid); end
        @(negedge clk); rst = 1'b1; #1;
        @(negedge clk); #1;
        checks++; if (req_valid !== 1'b0 || req_addr !== RESET_PC || ins_valid !== 1'b0 || {ins_out, pc_out, next_pc_out} !== 96'h0) begin
            errors++; $display("FAIL rmd_reset_state: got rv=%b addr=%h iv=%b %h %h %h expected 0 %h 0 zeros", req_valid, req_addr, ins_valid, ins_out, pc_out, next_pc_out, RESET_PC);
        end
        mem_hold = 0;
        @(negedge clk); rst = 1'b0; #1;
        checks++; if (req_valid !== 1'b1 || req_addr !== RESET_PC) begin errors++; $display("FAIL rmd_first_req: got rv=%b addr=%h expected 1 %h", req_valid, req_addr, RESET_PC); end
    endtask

    task automatic test_random();
        logic [31:0] e_ins, e_pc, e_next;
        set_mem(1, 1, 1, 1);
        reset_dut(2);
        for (int c = 0; c < 3000; c++) begin
            if (c > 0) @(negedge clk);
            ins_ready = ($urandom_range(0, 2) != 0);
            do_jump   = ($urandom_range(0, 29) == 0);
            jump_addr = $urandom & 32'hFFFF_FFFC;
            #1;
            e_ins  = (m_q.size() > 0) ? m_q[0].d : 32'h0;
            e_pc   = (m_q.size() > 0) ? m_q[0].pc : 32'h0;
            e_next = (m_q.size() > 0) ? m_q[0].pc + 32'h4 : 32'h0;
            checks++; if (req_valid !== exp_req_valid() || req_addr !== m_fetch) begin errors++; $display("FAIL rand_req c=%0d: got %b %h expected %b %h", c, req_valid, req_addr, exp_req_valid(), m_fetch); end
            checks++; if (ins_valid !== (m_q.size() > 0)) begin errors++; $display("FAIL rand_ins_valid c=%0d: got %b expected %b", c, ins_valid, m_q.size() > 0); end
            checks++; if (ins_out !== e_ins || pc_out !== e_pc || next_pc_out !== e_next) begin errors++; $display("FAIL rand_head c=%0d: got %h %h %h expected %h %h %h", c, ins_out, pc_out, next_pc_out, e_ins, e_pc, e_next); end
        end
        do_jump = 1'b0; ins_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_jump_drain();
        test_jump_resp_pop();
        test_steady();
        test_reset_mid_drain();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
